// File: rtl/sys_periph_responder_pkg.sv
// Shared definitions for the memory-mapped board I/O responder: offsets, FSM encodings, request payload, glyph table.
package sys_periph_responder_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OFF_W  = 8;
   localparam int unsigned HEX_N  = 6;

   localparam logic [OFF_W-1:0] OFF_LEDR  = 8'h00;
   localparam logic [OFF_W-1:0] OFF_SW    = 8'h04;
   localparam logic [OFF_W-1:0] OFF_HEX   = 8'h08;
   localparam logic [OFF_W-1:0] OFF_BLANK = 8'h0C;
   localparam logic [OFF_W-1:0] OFF_TIMER = 8'h10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   localparam logic [HEX_N-1:0] BLANK_RST = 6'h3F;

   // Request captured at the start of a bus cycle; only implemented data bits are kept.
   typedef struct packed {
      logic             fetch;
      logic             wr;
      logic [2:0]       strb;
      logic [23:0]      wdata;
      logic [OFF_W-1:0] off;
   } req_t;

   // Active-low {g,f,e,d,c,b,a} glyphs for 0-F.
   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h40;
         4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;
         4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;
         4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;
         4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;
         4'h9: hex_glyph = 7'h10;
         4'hA: hex_glyph = 7'h08;
         4'hB: hex_glyph = 7'h03;
         4'hC: hex_glyph = 7'h46;
         4'hD: hex_glyph = 7'h21;
         4'hE: hex_glyph = 7'h06;
         default: hex_glyph = 7'h0E;
      endcase
   endfunction

endpackage

// File: rtl/sys_periph_responder_hex7seg.sv
// One seven-segment digit decoder: nibble plus blank in, active-low segments out.
module hex7seg
   import sys_periph_responder_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   assign o_seg = i_blank ? 7'h7F : hex_glyph(i_nibble);

endmodule

// File: rtl/sys_periph_responder.sv
// picorv32 native-bus responder for board I/O (LEDR, SW, hex digits, blank mask) with wait states.
// Optional free-running cycle counter at offset 0x10 when PERIPH_TIMER_EN is defined.
module sys_periph_responder
   import sys_periph_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              sys_clk,
   input  logic              sys_resetn,
   input  logic              cpu_rw_cycle,
   input  logic              cpu_instr_fetch,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_write_data,
   input  logic [3:0]        cpu_write_strobe,
   output logic [DATA_W-1:0] cpu_read_data,
   output logic              sys_rw_is_done,
   output logic              periph_hit,
   input  logic [7:0]        SW,
   output logic [7:0]        LEDR,
   output logic [6:0]        hex0,
   output logic [6:0]        hex1,
   output logic [6:0]        hex2,
   output logic [6:0]        hex3,
   output logic [6:0]        hex4,
   output logic [6:0]        hex5
);

   logic [1:0]        r_state, w_state_nx;
   logic [3:0]        r_wcnt, w_wcnt_nx;
   req_t              r_req, w_req_live, w_rd_req;
   logic [DATA_W-1:0] r_rdata, w_rdata;
   logic              r_done, w_enter_ack, w_start, w_wr_ack;
   logic [7:0]        r_ledr, r_sw_m, r_sw_s;
   logic [23:0]       r_hex;
   logic [HEX_N-1:0]  r_blank;
   logic [6:0]        w_seg [HEX_N];
   logic              w_unused;
`ifdef PERIPH_TIMER_EN
   logic [31:0]       r_timer;
`endif

   assign periph_hit = (cpu_address[31:8] == BASE_ADDR[31:8]);
   assign w_start    = cpu_rw_cycle && periph_hit;
   assign w_unused   = ^cpu_write_data[31:24];

   assign w_req_live = '{fetch: cpu_instr_fetch, wr: |cpu_write_strobe,
                         strb: cpu_write_strobe[2:0], wdata: cpu_write_data[23:0],
                         off: cpu_address[OFF_W-1:0]};
   // With zero wait states the read is decoded straight from the live request.
   assign w_rd_req    = (r_state == ST_IDLE) ? w_req_live : r_req;
   assign w_enter_ack = (w_state_nx == ST_ACK) && (r_state != ST_ACK);
   assign w_wr_ack    = (r_state == ST_ACK) && r_req.wr && !r_req.fetch;

   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_state <= ST_IDLE;
         r_wcnt  <= 4'd0;
      end else begin
         r_state <= w_state_nx;
         r_wcnt  <= w_wcnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_wcnt_nx  = r_wcnt;
      case (r_state)
         ST_IDLE: if (w_start) begin
            w_wcnt_nx  = 4'd0;
            w_state_nx = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wcnt == 4'(WAIT_STATES - 1)) w_state_nx = ST_ACK;
            else                               w_wcnt_nx  = r_wcnt + 4'd1;
         end
         ST_ACK:  w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rdata = '0;
      if (!w_rd_req.fetch) begin
         case (w_rd_req.off)
            OFF_LEDR:  w_rdata = {24'd0, r_ledr};
            OFF_SW:    w_rdata = {24'd0, r_sw_s};
            OFF_HEX:   w_rdata = {8'd0, r_hex};
            OFF_BLANK: w_rdata = {26'd0, r_blank};
`ifdef PERIPH_TIMER_EN
            OFF_TIMER: w_rdata = r_timer;
`endif
            default:   w_rdata = '0;
         endcase
      end
   end

   // Bus-side registers: request latch, read data and done pulse.
   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_req   <= '0;
         r_rdata <= '0;
         r_done  <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_start) r_req <= w_req_live;
         if (w_enter_ack)                     r_rdata <= w_rdata;
         else if (r_state == ST_ACK)          r_rdata <= '0;
         r_done <= w_enter_ack;
      end
   end

   // Board registers, written as the ACK cycle closes.
   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_ledr  <= 8'd0;
         r_hex   <= 24'd0;
         r_blank <= BLANK_RST;
         r_sw_m  <= 8'd0;
         r_sw_s  <= 8'd0;
      end else begin
         r_sw_m <= SW;
         r_sw_s <= r_sw_m;
         if (w_wr_ack) begin
            case (r_req.off)
               OFF_LEDR:  if (r_req.strb[0]) r_ledr <= r_req.wdata[7:0];
               OFF_HEX: begin
                  if (r_req.strb[0]) r_hex[7:0]   <= r_req.wdata[7:0];
                  if (r_req.strb[1]) r_hex[15:8]  <= r_req.wdata[15:8];
                  if (r_req.strb[2]) r_hex[23:16] <= r_req.wdata[23:16];
               end
               OFF_BLANK: if (r_req.strb[0]) r_blank <= r_req.wdata[5:0];
               default: ;
            endcase
         end
      end
   end

`ifdef PERIPH_TIMER_EN
   // A clearing write takes priority over the increment.
   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn)                           r_timer <= 32'd0;
      else if (w_wr_ack && r_req.off == OFF_TIMER) r_timer <= 32'd0;
      else                                       r_timer <= r_timer + 32'd1;
   end
`endif

   for (genvar k = 0; k < HEX_N; k++) begin : g_hex
      hex7seg u_hex7seg (
         .i_nibble (r_hex[4*k +: 4]),
         .i_blank  (r_blank[k]),
         .o_seg    (w_seg[k])
      );
   end

   assign hex0 = w_seg[0];
   assign hex1 = w_seg[1];
   assign hex2 = w_seg[2];
   assign hex3 = w_seg[3];
   assign hex4 = w_seg[4];
   assign hex5 = w_seg[5];

   assign cpu_read_data  = r_rdata;
   assign sys_rw_is_done = r_done;
   assign LEDR           = r_ledr;

endmodule

// File: tb/tb_sys_periph_responder.sv
// Directed bench for sys_periph_responder with a read-data scoreboard; PERIPH_TIMER_EN adds timer steps.
module tb_sys_periph_responder;

   logic        sys_clk = 1'b0;
   logic        sys_resetn;
   logic        cpu_rw_cycle, cpu_instr_fetch;
   logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
   logic [3:0]  cpu_write_strobe;
   logic        sys_rw_is_done, periph_hit;
   logic [7:0]  SW, LEDR;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

   int          n_vec  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   int unsigned cyc = 0;

   localparam int unsigned WS = 1;

   sys_periph_responder #(.BASE_ADDR(32'h1000_0000), .WAIT_STATES(WS)) dut (
      .sys_clk(sys_clk), .sys_resetn(sys_resetn),
      .cpu_rw_cycle(cpu_rw_cycle), .cpu_instr_fetch(cpu_instr_fetch),
      .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
      .cpu_write_strobe(cpu_write_strobe), .cpu_read_data(cpu_read_data),
      .sys_rw_is_done(sys_rw_is_done), .periph_hit(periph_hit),
      .SW(SW), .LEDR(LEDR),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
   );

   always #10 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One in-window bus cycle: checks latency and that done is a single-cycle pulse.
   task automatic bus(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic fetch, output logic [31:0] rd);
      int lat;
      lat = 0;
      rd  = 32'h0;
      cpu_address = a; cpu_write_data = wd; cpu_write_strobe = st;
      cpu_instr_fetch = fetch; cpu_rw_cycle = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge sys_clk);
         if (sys_rw_is_done) begin
            lat = k;
            rd  = cpu_read_data;
            break;
         end
      end
      if (lat == 0) check({tag, "_timeout"}, {31'd0, sys_rw_is_done}, 32'd1);
      else          check({tag, "_latency"}, lat, WS + 1);
      cpu_rw_cycle = 1'b0; cpu_write_strobe = 4'h0; cpu_instr_fetch = 1'b0;
      @(negedge sys_clk);
      check({tag, "_pulse"}, {31'd0, sys_rw_is_done}, 32'd0);
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st);
      logic [31:0] rd;
      bus(tag, a, wd, st, 1'b0, rd);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input logic fetch);
      logic [31:0] rd;
      exp_q.push_back(exp);
      bus(tag, a, 32'h0, 4'h0, fetch, rd);
      check(tag, rd, exp_q.pop_front());
   endtask

   initial begin
      logic        seen;
      logic [31:0] t1, t2;
      int unsigned c1, c2;

      sys_resetn = 1'b0; cpu_rw_cycle = 1'b0; cpu_instr_fetch = 1'b0;
      cpu_address = 32'h0; cpu_write_data = 32'h0; cpu_write_strobe = 4'h0; SW = 8'h00;
      repeat (3) @(negedge sys_clk);
      sys_resetn = 1'b1;
      repeat (2) @(negedge sys_clk);

      check("rst_ledr", {24'd0, LEDR}, 32'h0);
      check("rst_done", {31'd0, sys_rw_is_done}, 32'h0);
      check("rst_rdata", cpu_read_data, 32'h0);
      check("rst_hex0", {25'd0, hex0}, 32'h7F);
      check("rst_hex3", {25'd0, hex3}, 32'h7F);
      check("rst_hex5", {25'd0, hex5}, 32'h7F);

      wr("w_ledr", 32'h1000_0000, 32'h0000_00A5, 4'b0001);
      check("ledr_a5", {24'd0, LEDR}, 32'hA5);
      rd_chk("r_ledr", 32'h1000_0000, 32'h0000_00A5, 1'b0);

      wr("w_ledr_nostrb", 32'h1000_0000, 32'h0000_7777, 4'b0010);
      check("ledr_strb", {24'd0, LEDR}, 32'hA5);
      wr("w_ledr_fetch", 32'h1000_0000, 32'h0000_0011, 4'b0001);
      check("ledr_after", {24'd0, LEDR}, 32'h11);
      rd_chk("r_fetch", 32'h1000_0000, 32'h0, 1'b1);

      wr("w_hex", 32'h1000_0008, 32'h0012_3456, 4'b0111);
      wr("w_blank0", 32'h1000_000C, 32'h0, 4'b0001);
      check("hex0_6", {25'd0, hex0}, 32'h02);
      check("hex1_5", {25'd0, hex1}, 32'h12);
      check("hex2_4", {25'd0, hex2}, 32'h19);
      check("hex3_3", {25'd0, hex3}, 32'h30);
      check("hex4_2", {25'd0, hex4}, 32'h24);
      check("hex5_1", {25'd0, hex5}, 32'h79);
      rd_chk("r_hex", 32'h1000_0008, 32'h0012_3456, 1'b0);
      wr("w_hex_b2", 32'h1000_0008, 32'h00AB_0000, 4'b0100);
      check("hex5_a", {25'd0, hex5}, 32'h08);
      check("hex4_b", {25'd0, hex4}, 32'h03);
      check("hex0_keep", {25'd0, hex0}, 32'h02);
      wr("w_blank1", 32'h1000_000C, 32'h0000_0001, 4'b0001);
      check("hex0_blank", {25'd0, hex0}, 32'h7F);
      check("hex1_on", {25'd0, hex1}, 32'h12);
      rd_chk("r_blank", 32'h1000_000C, 32'h0000_0001, 1'b0);

      SW = 8'h55;
      repeat (3) @(negedge sys_clk);
      rd_chk("r_sw", 32'h1000_0004, 32'h0000_0055, 1'b0);
      wr("w_sw", 32'h1000_0004, 32'h0000_00FF, 4'b1111);
      rd_chk("r_sw2", 32'h1000_0004, 32'h0000_0055, 1'b0);

      cpu_address = 32'h2000_0000; cpu_write_strobe = 4'h0; cpu_rw_cycle = 1'b1;
      #1;
      check("miss_hit", {31'd0, periph_hit}, 32'h0);
      seen = 1'b0;
      repeat (10) begin
         @(negedge sys_clk);
         if (sys_rw_is_done) seen = 1'b1;
      end
      check("miss_done", {31'd0, seen}, 32'h0);
      cpu_rw_cycle = 1'b0;
      @(negedge sys_clk);
      rd_chk("r_unmapped", 32'h1000_0040, 32'h0, 1'b0);
      rd_chk("r_topwin", 32'h1000_00FC, 32'h0, 1'b0);

`ifdef PERIPH_TIMER_EN
      c1 = cyc;
      bus("t_rd1", 32'h1000_0010, 32'h0, 4'h0, 1'b0, t1);
      repeat (7) @(negedge sys_clk);
      c2 = cyc;
      bus("t_rd2", 32'h1000_0010, 32'h0, 4'h0, 1'b0, t2);
      check("timer_diff", t2 - t1, c2 - c1);
      wr("t_clr", 32'h1000_0010, 32'h0, 4'b1000);
      rd_chk("timer_clr", 32'h1000_0010, 32'h0000_0001, 1'b0);
`else
      t1 = 32'h0; t2 = 32'h0; c1 = 0; c2 = 0;
      rd_chk("r_notimer", 32'h1000_0010, 32'h0, 1'b0);
`endif

      wr("w_ledr_pre", 32'h1000_0000, 32'h0000_003C, 4'b0001);
      check("ledr_3c", {24'd0, LEDR}, 32'h3C);
      cpu_address = 32'h1000_0000; cpu_write_data = 32'h0000_00C3;
      cpu_write_strobe = 4'b0001; cpu_rw_cycle = 1'b1;
      @(negedge sys_clk);
      sys_resetn = 1'b0;
      #2;
      check("rstmid_ledr", {24'd0, LEDR}, 32'h0);
      check("rstmid_done", {31'd0, sys_rw_is_done}, 32'h0);
      cpu_rw_cycle = 1'b0; cpu_write_strobe = 4'h0;
      @(negedge sys_clk);
      sys_resetn = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rstpost_ledr", {24'd0, LEDR}, 32'h0);
      check("rstpost_done", {31'd0, sys_rw_is_done}, 32'h0);
      check("rstpost_hex0", {25'd0, hex0}, 32'h7F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
